// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: two line buffers build a raster window, one or
// two signed kernels are applied, and the result is rectified, combined,
// saturated and tagged with the window-centre coordinates.
module conv3x3_stream #(
  parameter int PIX_W   = 12,
  parameter int COORD_W = 11,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int COEF_W  = 3,
  parameter int SHIFT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [PIX_W-1:0]      in_pixel,
  input  logic [COORD_W-1:0]    in_x,
  input  logic [COORD_W-1:0]    in_y,
  input  logic [1:0]            mode,
  input  logic [9*COEF_W-1:0]   coef_a,
  input  logic [9*COEF_W-1:0]   coef_b,
  output logic                  out_valid,
  output logic [PIX_W-1:0]      out_pixel,
  output logic [COORD_W-1:0]    out_x,
  output logic [COORD_W-1:0]    out_y
);
  localparam int STAGES = 3;
  localparam int PROD_W = PIX_W + 1 + COEF_W;
  localparam int SUM_W  = PIX_W + COEF_W + 4;
  localparam int AW     = $clog2(IMG_W);
  localparam int FILL_W = $clog2(IMG_W + 2);
  localparam int LB1_W  = PIX_W + 2 * COORD_W;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(IMG_W + 1);
  localparam logic [PIX_W-1:0]  PIX_MAX  = '1;

  // line buffer 1 carries coordinates so the centre tag travels with its pixel
  logic [LB1_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];
  logic [AW-1:0]    ptr;
  logic [LB1_W-1:0] lb1_rd;
  logic [PIX_W-1:0] lb2_rd;

  logic [2:0][2:0][PIX_W-1:0] win;
  logic [COORD_W-1:0] cx1, cy1, cx2, cy2;
  logic [FILL_W-1:0]  fill;
  logic               armed;
  logic               frame_start, qualify;
  logic [STAGES:0]    vld_pipe;

  logic signed [PROD_W-1:0] prod_a [9];
  logic signed [PROD_W-1:0] prod_b [9];
  logic [1:0]               s1_mode, s2_mode;
  logic [PIX_W-1:0]         s1_pix, s2_pix;
  logic [COORD_W-1:0]       s1_x, s1_y, s2_x, s2_y;
  logic signed [SUM_W-1:0]  sum_a_c, sum_b_c, sum_a, sum_b;
  logic signed [SUM_W-1:0]  sh_a, sh_b;
  logic [SUM_W-1:0]         abs_a, abs_b;
  logic [SUM_W:0]           mag;
  logic [PIX_W-1:0]         res;
  logic                     border;

  function automatic logic signed [PROD_W-1:0] mul(input logic [PIX_W-1:0] p,
                                                   input logic [COEF_W-1:0] c);
    logic signed [PROD_W-1:0] ps, cs;
    ps  = PROD_W'({1'b0, p});
    cs  = PROD_W'($signed(c));
    mul = ps * cs;
  endfunction

  assign lb1_rd      = lb1[ptr];
  assign lb2_rd      = lb2[ptr];
  assign frame_start = (in_x == '0) && (in_y == '0);
  // armed blocks output after reset until a real frame start is seen
  assign qualify     = in_valid && armed && !frame_start && (fill == FILL_MAX);

  // line buffer storage; contents need no reset
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1[ptr] <= {in_x, in_y, in_pixel};
      lb2[ptr] <= lb1_rd[PIX_W-1:0];
    end
  end

  // circular line-buffer pointer, fill counter and frame arming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      fill  <= '0;
      armed <= 1'b0;
    end else if (in_valid) begin
      ptr <= (ptr == AW'(IMG_W - 1)) ? '0 : ptr + 1'b1;
      if (frame_start) begin
        fill  <= FILL_W'(1);
        armed <= 1'b1;
      end else if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // window shift: column 2 is newest, row 2 is the current line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
      cx1 <= '0; cy1 <= '0; cx2 <= '0; cy2 <= '0;
    end else if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[2][2] <= in_pixel;
      win[1][2] <= lb1_rd[PIX_W-1:0];
      win[0][2] <= lb2_rd;
      {cx2, cy2} <= lb1_rd[LB1_W-1:PIX_W];
      cx1 <= cx2;
      cy1 <= cy2;
    end
  end

  // qualifying-beat valid travelling with the data pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:0], qualify};
  end

  // stage 1: nine products per kernel, mode and centre captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) begin
        prod_a[k] <= '0;
        prod_b[k] <= '0;
      end
      s1_mode <= '0; s1_pix <= '0; s1_x <= '0; s1_y <= '0;
    end else begin
      for (int k = 0; k < 9; k++) begin
        prod_a[k] <= mul(win[k/3][k%3], coef_a[k*COEF_W +: COEF_W]);
        prod_b[k] <= mul(win[k/3][k%3], coef_b[k*COEF_W +: COEF_W]);
      end
      s1_mode <= mode; s1_pix <= win[1][1]; s1_x <= cx1; s1_y <= cy1;
    end
  end

  // adder trees for both kernels
  always_comb begin
    sum_a_c = '0;
    sum_b_c = '0;
    for (int k = 0; k < 9; k++) begin
      sum_a_c = sum_a_c + SUM_W'(prod_a[k]);
      sum_b_c = sum_b_c + SUM_W'(prod_b[k]);
    end
  end

  // stage 2: registered kernel sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_a <= '0; sum_b <= '0;
      s2_mode <= '0; s2_pix <= '0; s2_x <= '0; s2_y <= '0;
    end else begin
      sum_a <= sum_a_c; sum_b <= sum_b_c;
      s2_mode <= s1_mode; s2_pix <= s1_pix; s2_x <= s1_x; s2_y <= s1_y;
    end
  end

  // scale, rectify, combine, saturate, then border / passthrough select
  always_comb begin
    sh_a   = sum_a >>> SHIFT;
    sh_b   = sum_b >>> SHIFT;
    abs_a  = sh_a[SUM_W-1] ? SUM_W'(-sh_a) : SUM_W'(sh_a);
    abs_b  = sh_b[SUM_W-1] ? SUM_W'(-sh_b) : SUM_W'(sh_b);
    mag    = {1'b0, abs_a};
    if (s2_mode == 2'd1) mag = {1'b0, abs_b};
    if (s2_mode == 2'd2) mag = {1'b0, abs_a} + {1'b0, abs_b};
    border = (s2_x == '0) || (s2_x == COORD_W'(IMG_W - 1)) ||
             (s2_y == '0) || (s2_y == COORD_W'(IMG_H - 1));
    res    = (mag > (SUM_W + 1)'(PIX_MAX)) ? PIX_MAX : mag[PIX_W-1:0];
    if (border)           res = '0;
    if (s2_mode == 2'd3)  res = s2_pix;
  end

  // stage 3: output register, updated only for valid results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pixel <= '0; out_x <= '0; out_y <= '0;
    end else if (vld_pipe[STAGES-1]) begin
      out_pixel <= res; out_x <= s2_x; out_y <= s2_y;
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on an 8x6 image, with SHIFT=2 and a
// second SHIFT=0 instance sharing the same stimulus.
module tb_conv3x3_stream;
  localparam int W = 8, H = 6, NOUT = W * H - (W + 1);

  logic        clk = 0, rst_n = 0, in_valid = 0;
  logic [11:0] in_pixel = 0;
  logic [10:0] in_x = 0, in_y = 0;
  logic [1:0]  mode = 0;
  logic [26:0] coef_a = 0, coef_b = 0;
  logic        ov, ov0;
  logic [11:0] op, op0;
  logic [10:0] ox, oy, ox0, oy0;

  typedef struct { int p; int x; int y; int cyc; } ent_t;
  ent_t q[$], q0[$], saved[$];
  int cyc = 0, b10 = 0, total = 0, bad = 0;
  logic [26:0] gx, gy;

  conv3x3_stream #(.PIX_W(12), .COORD_W(11), .IMG_W(W), .IMG_H(H), .COEF_W(3), .SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel), .in_x(in_x), .in_y(in_y),
    .mode(mode), .coef_a(coef_a), .coef_b(coef_b),
    .out_valid(ov), .out_pixel(op), .out_x(ox), .out_y(oy));

  conv3x3_stream #(.PIX_W(12), .COORD_W(11), .IMG_W(W), .IMG_H(H), .COEF_W(3), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel), .in_x(in_x), .in_y(in_y),
    .mode(mode), .coef_a(coef_a), .coef_b(coef_b),
    .out_valid(ov0), .out_pixel(op0), .out_x(ox0), .out_y(oy0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ov)  q.push_back('{int'(op), int'(ox), int'(oy), cyc});
    if (ov0) q0.push_back('{int'(op0), int'(ox0), int'(oy0), cyc});
  end

  // image library: 0 flat 100, 1 vertical 0/400 step, 2 vertical 0/4095 step,
  // 3 horizontal 0/400 step (rows 4,5 bright)
  function automatic int pix(int img, int x, int y);
    case (img)
      0: return 100;
      1: return (x < 4) ? 0 : 400;
      2: return (x < 4) ? 0 : 4095;
      default: return (y < 4) ? 0 : 400;
    endcase
  endfunction

  function automatic int ksum(int img, logic [26:0] c, int sh, int x, int y);
    int s, t;
    s = 0;
    for (int k = 0; k < 9; k++) begin
      t = $signed(c[k*3 +: 3]);
      s += t * pix(img, x - 1 + k % 3, y - 1 + k / 3);
    end
    s = s >>> sh;
    return (s < 0) ? -s : s;
  endfunction

  function automatic int expv(int img, int md, int sh, int x, int y);
    int m;
    if (md == 3) return pix(img, x, y);
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
    if (md == 0)      m = ksum(img, coef_a, sh, x, y);
    else if (md == 1) m = ksum(img, coef_b, sh, x, y);
    else              m = ksum(img, coef_a, sh, x, y) + ksum(img, coef_b, sh, x, y);
    return (m > 4095) ? 4095 : m;
  endfunction

  task automatic send(input int img, input int gap, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      in_valid = 1; in_x = 11'(i % W); in_y = 11'(i / W); in_pixel = 12'(pix(img, i % W, i / W));
      if (i == 9) b10 = cyc;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid = 0; in_pixel = 12'hABC;
      end
    end
    @(negedge clk);
    in_valid = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input int img, input int md, input int sh, input int use0);
    ent_t e;
    int n, ev;
    n = use0 ? q0.size() : q.size();
    total++;
    if (n !== NOUT) begin
      bad++; $display("FAIL %s count got=%0d want=%0d", nm, n, NOUT);
    end
    for (int i = 0; i < n && i < NOUT; i++) begin
      e = use0 ? q0[i] : q[i];
      ev = expv(img, md, sh, i % W, i / W);
      total++;
      if (e.p !== ev || e.x !== i % W || e.y !== i / W) begin
        bad++;
        $display("FAIL %s #%0d got p=%0d x=%0d y=%0d want p=%0d x=%0d y=%0d",
                 nm, i, e.p, e.x, e.y, ev, i % W, i / W);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++;
    if (ov !== 1'b0 || op !== 12'd0 || ox !== 11'd0 || oy !== 11'd0) begin
      bad++; $display("FAIL reset got v=%b p=%0d x=%0d y=%0d want all 0", ov, op, ox, oy);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_passthrough;
    q.delete(); mode = 3;
    send(0, 0, 0, W * H - 1);
    check_frame("pass", 0, 3, 2, 0);
    total++;
    if (q.size() == 0 || q[0].cyc - (b10 + 1) !== 3) begin
      bad++; $display("FAIL pass_latency got=%0d want=3", q.size() ? q[0].cyc - (b10 + 1) : -1);
    end
  endtask

  task automatic test_sobel_flat;
    q.delete(); mode = 0; coef_a = gx;
    send(0, 0, 0, W * H - 1);
    check_frame("flat_gx", 0, 0, 2, 0);
  endtask

  task automatic test_edge;
    q.delete(); q0.delete(); mode = 0; coef_a = gx;
    send(1, 0, 0, W * H - 1);
    check_frame("edge_gx", 1, 0, 2, 0);
    total++;
    if (q.size() < 20 || q[19].p !== 400 || q[20].p !== 400 || q[21].p !== 0) begin
      bad++; $display("FAIL edge_hand got (3,2)=%0d (4,2)=%0d (5,2)=%0d want 400 400 0",
                      q.size() > 21 ? q[19].p : -1, q.size() > 21 ? q[20].p : -1, q.size() > 21 ? q[21].p : -1);
    end
    saved = q;
  endtask

  task automatic test_saturate;
    q0.delete(); mode = 0; coef_a = gx;
    send(2, 0, 0, W * H - 1);
    check_frame("sat_shift0", 2, 0, 0, 1);
    total++;
    if (q0.size() < 20 || q0[19].p !== 4095) begin
      bad++; $display("FAIL sat_hand got=%0d want=4095", q0.size() > 19 ? q0[19].p : -1);
    end
  endtask

  task automatic test_mode2;
    q.delete(); mode = 2; coef_a = gx; coef_b = gy;
    send(1, 0, 0, W * H - 1);
    check_frame("mag_vert", 1, 2, 2, 0);
    q.delete();
    send(3, 0, 0, W * H - 1);
    check_frame("mag_horz", 3, 2, 2, 0);
    total++;
    if (q.size() < 36 || q[26].p !== 400 || q[34].p !== 400 || q[18].p !== 0) begin
      bad++; $display("FAIL mag_hand got (2,3)=%0d (2,4)=%0d (2,2)=%0d want 400 400 0",
                      q.size() > 34 ? q[26].p : -1, q.size() > 34 ? q[34].p : -1, q.size() > 34 ? q[18].p : -1);
    end
  endtask

  task automatic test_gaps;
    q.delete(); mode = 0; coef_a = gx;
    send(1, 2, 0, W * H - 1);
    total++;
    if (q.size() !== saved.size()) begin
      bad++; $display("FAIL gaps_count got=%0d want=%0d", q.size(), saved.size());
    end
    for (int i = 0; i < q.size() && i < saved.size(); i++) begin
      total++;
      if (q[i].p !== saved[i].p || q[i].x !== saved[i].x || q[i].y !== saved[i].y) begin
        bad++; $display("FAIL gaps #%0d got p=%0d x=%0d y=%0d want p=%0d x=%0d y=%0d",
                        i, q[i].p, q[i].x, q[i].y, saved[i].p, saved[i].x, saved[i].y);
      end
    end
  endtask

  task automatic test_mid_reset;
    mode = 3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1; in_x = 11'(i % W); in_y = 11'(i / W); in_pixel = 12'd100;
    end
    @(negedge clk);
    in_valid = 0;
    rst_n = 0;
    #1;
    total++;
    if (ov !== 1'b0 || op !== 12'd0) begin
      bad++; $display("FAIL midrst_clear got v=%b p=%0d want v=0 p=0", ov, op);
    end
    @(negedge clk);
    rst_n = 1;
    q.delete();
    send(0, 0, 20, W * H - 1);
    total++;
    if (q.size() !== 0) begin
      bad++; $display("FAIL midrst_quiet got=%0d outputs want=0", q.size());
    end
    q.delete();
    send(0, 0, 0, W * H - 1);
    check_frame("midrst_next", 0, 3, 2, 0);
    total++;
    if (q.size() == 0 || q[0].cyc - (b10 + 1) !== 3) begin
      bad++; $display("FAIL midrst_latency got=%0d want=3", q.size() ? q[0].cyc - (b10 + 1) : -1);
    end
  endtask

  initial begin
    int tx[9], ty[9];
    tx = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    ty = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    for (int k = 0; k < 9; k++) begin
      gx[k*3 +: 3] = 3'(tx[k]);
      gy[k*3 +: 3] = 3'(ty[k]);
    end
    test_reset();
    test_passthrough();
    test_sobel_flat();
    test_edge();
    test_saturate();
    test_mode2();
    test_gaps();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
